drp_wb: RTL and testbench
=========================

// Module: drp_wb
// PURPOSE
//   DRP-to-Wishbone bridge: DRP responder (slave) on one side, Wishbone master on the other.
//   Each DRP access (drp_en pulse) becomes exactly one 16-bit Wishbone classic cycle.
//   The block answers with a single-cycle drp_rdy and read data.
//   Lets DRP-only masters (XFCP DRP ports, DRP-driven controllers) reach Wishbone register space.
//   A timeout counter guarantees drp_rdy is always returned.
// PARAMETERS
//   ADDR_WIDTH    16       width of drp_addr and wb_adr_o
//   TIMEOUT       1024     clocks in CYCLE before abort; 0 disables timeout
//   TIMEOUT_WIDTH 11       width of timeout counter; must hold TIMEOUT
// PORTS
//   clk        in   1           clock, all logic on rising edge
//   rst        in   1           synchronous active-high reset
//   drp_addr   in   ADDR_WIDTH  DRP address, sampled when drp_en=1
//   drp_di     in   16          DRP write data from master, sampled when drp_en=1
//   drp_do     out  16          DRP read data, valid when drp_rdy=1
//   drp_en     in   1           DRP enable, one-cycle request pulse
//   drp_we     in   1           DRP write enable, qualified by drp_en
//   drp_rdy    out  1           one-cycle completion pulse
//   wb_adr_o   out  ADDR_WIDTH  Wishbone address
//   wb_dat_i   in   16          Wishbone read data
//   wb_dat_o   out  16          Wishbone write data
//   wb_we_o    out  1           Wishbone write enable
//   wb_sel_o   out  2           byte select, constant 2'b11
//   wb_stb_o   out  1           Wishbone strobe
//   wb_ack_i   in   1           Wishbone acknowledge
//   wb_err_i   in   1           Wishbone error
//   wb_cyc_o   out  1           Wishbone cycle
//   busy       out  1           high while state != IDLE
//   err        out  1           one-cycle pulse with drp_rdy on bus error or timeout
//   timeout    out  1           one-cycle pulse with drp_rdy on timeout abort
// BEHAVIOUR
//   Outputs: all registered.
//   Reset values: wb_cyc_o=wb_stb_o=wb_we_o=0; drp_rdy=err=timeout=busy=0;
//     wb_adr_o=0, wb_dat_o=0, drp_do=0; state=IDLE.
//   FSM: IDLE, CYCLE.
//   IDLE:
//     - drp_en=1 at edge N: latch drp_addr->wb_adr_o, drp_di->wb_dat_o, drp_we->wb_we_o.
//     - Assert wb_cyc_o=wb_stb_o=1 and busy=1 after edge N; load timeout counter with TIMEOUT.
//     - Go to CYCLE.
//     - wb_ack_i/wb_err_i while IDLE: ignored.
//   CYCLE:
//     - wb_adr_o, wb_dat_o, wb_we_o, cyc and stb held stable until termination.
//     - Counter decrements every clock.
//     - wb_ack_i=1 at edge M: cyc/stb/busy drop after M; drp_rdy=1 for the cycle after M.
//       On read, drp_do<=wb_dat_i. On write, drp_do unchanged. Return to IDLE.
//     - wb_err_i=1 at edge M: same as ack, but drp_do<=16'h0000 and err=1.
//     - ack and err at the same edge: err wins.
//     - Counter reaches 0 (TIMEOUT!=0) with no ack/err: abort identically to err, plus timeout=1.
//       drp_rdy rises exactly TIMEOUT+1 clocks after the request edge.
//     - ack/err at the same edge as counter expiry: ack/err wins; timeout=0.
//   Latency: zero-wait slave (ack in the first CYCLE clock) gives drp_rdy 2 clocks after drp_en.
//   drp_do holds its last value between transactions; valid only when drp_rdy=1.
//   drp_en while busy=1: protocol violation. Ignored; no second Wishbone cycle.
//     Current transaction completes normally.
//   drp_en in the same clock drp_rdy=1: accepted (FSM already IDLE), back-to-back allowed.
//   rst mid-CYCLE: cyc/stb drop at the next edge; no drp_rdy for the aborted access.
//   No combinational path from any input to any output.
// TESTING
//   Read, zero-wait: drp_en, addr=16'h0012, slave acks at first stb with 16'hBEEF
//     -> wb_adr_o=0x0012, we=0; drp_rdy 2 clks after en; drp_do=0xBEEF.
//   Write, 3 wait states: en, we=1, di=16'h5A5A, addr=0x0034
//     -> wb_dat_o=0x5A5A held 4 clks; one drp_rdy; drp_do unchanged.
//   Bus error on read -> drp_rdy, err=1, drp_do=0x0000; wb_cyc_o low next clk.
//   TIMEOUT=8, slave never acks -> drp_rdy, err and timeout exactly 9 clks after en; cyc low.
//   Back-to-back: second en in the drp_rdy cycle -> accepted; stray en while busy -> ignored.
//   rst asserted mid-CYCLE -> cyc/stb low next clk; no drp_rdy; next en works normally.

Source files
------------

// File: rtl/drp_wb_if.sv
// Wishbone classic bus bundle used between the DRP bridge and its
// Wishbone slave. The bridge drives this bundle through the master modport,
// and a slave device drives it through the slave modport.
interface drp_wb_if #(
    parameter int ADDR_WIDTH = 16
) ();

    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [15:0]           wb_dat_i;
    logic [15:0]           wb_dat_o;
    logic                  wb_we_o;
    logic [1:0]            wb_sel_o;
    logic                  wb_stb_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_cyc_o;

    modport master (
        output wb_adr_o,
        output wb_dat_o,
        output wb_we_o,
        output wb_sel_o,
        output wb_stb_o,
        output wb_cyc_o,
        input  wb_dat_i,
        input  wb_ack_i,
        input  wb_err_i
    );

    modport slave (
        input  wb_adr_o,
        input  wb_dat_o,
        input  wb_we_o,
        input  wb_sel_o,
        input  wb_stb_o,
        input  wb_cyc_o,
        output wb_dat_i,
        output wb_ack_i,
        output wb_err_i
    );

endinterface

// File: rtl/drp_wb.sv
// DRP-to-Wishbone bridge. Each drp_en pulse becomes one 16-bit Wishbone
// classic cycle; the access is answered with a single-cycle drp_rdy.
// A down-counter aborts a cycle the slave never terminates, so drp_rdy is
// always returned (TIMEOUT = 0 disables the abort). All outputs come
// straight from flops.
module drp_wb #(
    parameter int ADDR_WIDTH    = 16,
    parameter int TIMEOUT       = 1024,
    parameter int TIMEOUT_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] drp_addr,
    input  logic [15:0]           drp_di,
    output logic [15:0]           drp_do,
    input  logic                  drp_en,
    input  logic                  drp_we,
    output logic                  drp_rdy,
    output logic                  busy,
    output logic                  err,
    output logic                  timeout,
    drp_wb_if.master              wb
);

    typedef enum logic {
        IDLE,
        CYCLE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LOAD = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] COUNT_ONE    = TIMEOUT_WIDTH'(1);
    localparam bit                       TIMEOUT_EN   = (TIMEOUT != 0);

    state_t                 state, state_next;
    logic [TIMEOUT_WIDTH-1:0] count, count_next;
    logic [ADDR_WIDTH-1:0]  adr, adr_next;
    logic [15:0]            dat, dat_next;
    logic                   we, we_next;
    logic [15:0]            rd_data, rd_data_next;
    logic                   rdy, rdy_next;
    logic                   err_q, err_next;
    logic                   to_q, to_next;

    // The counter sits at 1 on the edge TIMEOUT clocks after the request
    // edge; aborting there puts drp_rdy TIMEOUT+1 clocks after drp_en.
    logic expire;
    assign expire = TIMEOUT_EN && (count == COUNT_ONE);

    // Next-state and next-register values; a slave response takes priority
    // over the timeout, and an error takes priority over an acknowledge.
    always_comb begin
        state_next   = state;
        count_next   = count;
        adr_next     = adr;
        dat_next     = dat;
        we_next      = we;
        rd_data_next = rd_data;
        rdy_next     = 1'b0;
        err_next     = 1'b0;
        to_next      = 1'b0;

        case (state)
            IDLE: begin
                if (drp_en) begin
                    adr_next   = drp_addr;
                    dat_next   = drp_di;
                    we_next    = drp_we;
                    count_next = TIMEOUT_LOAD;
                    state_next = CYCLE;
                end
            end
            CYCLE: begin
                if (count != '0) begin
                    count_next = count - COUNT_ONE;
                end
                if (wb.wb_err_i) begin
                    rd_data_next = 16'h0000;
                    rdy_next     = 1'b1;
                    err_next     = 1'b1;
                    state_next   = IDLE;
                end else if (wb.wb_ack_i) begin
                    if (!we) begin
                        rd_data_next = wb.wb_dat_i;
                    end
                    rdy_next   = 1'b1;
                    state_next = IDLE;
                end else if (expire) begin
                    rd_data_next = 16'h0000;
                    rdy_next     = 1'b1;
                    err_next     = 1'b1;
                    to_next      = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            adr     <= '0;
            dat     <= 16'h0000;
            we      <= 1'b0;
            rd_data <= 16'h0000;
            rdy     <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            adr     <= adr_next;
            dat     <= dat_next;
            we      <= we_next;
            rd_data <= rd_data_next;
            rdy     <= rdy_next;
            err_q   <= err_next;
            to_q    <= to_next;
        end
    end

    assign wb.wb_adr_o = adr;
    assign wb.wb_dat_o = dat;
    assign wb.wb_we_o  = we;
    assign wb.wb_sel_o = 2'b11;
    assign wb.wb_cyc_o = (state == CYCLE);
    assign wb.wb_stb_o = (state == CYCLE);
    assign busy        = (state == CYCLE);
    assign drp_do      = rd_data;
    assign drp_rdy     = rdy;
    assign err         = err_q;
    assign timeout     = to_q;

endmodule

// File: tb/tb_drp_wb.sv
// Testbench for drp_wb: a transaction-level model predicts every output
// each clock, a Wishbone slave responds with chosen or random wait states,
// and directed scenarios pin the model with literal expectations before a
// long randomized run.
module tb_drp_wb;

    localparam int TO = 8;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_en;
    logic        drp_we;
    logic        drp_rdy;
    logic        busy;
    logic        err;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit compare_on = 1'b0;

    // slave configuration and state
    bit          cfg_random = 1'b0;
    int          cfg_wait   = 0;
    int          cfg_kind   = K_ACK;
    logic [15:0] cfg_data   = 16'h0000;
    bit          slave_active = 1'b0;
    int          wait_left = 0;
    int          kind = K_ACK;

    // model state
    bit          m_active = 1'b0;
    int          m_age = 0;
    logic [15:0] m_adr = 16'h0000;
    logic [15:0] m_dat = 16'h0000;
    logic        m_we = 1'b0;
    logic [15:0] m_do = 16'h0000;
    logic        m_rdy = 1'b0;
    logic        m_err = 1'b0;
    logic        m_to = 1'b0;

    drp_wb_if #(.ADDR_WIDTH(16)) wb ();

    drp_wb #(
        .ADDR_WIDTH(16),
        .TIMEOUT(TO),
        .TIMEOUT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .drp_addr(drp_addr),
        .drp_di(drp_di),
        .drp_do(drp_do),
        .drp_en(drp_en),
        .drp_we(drp_we),
        .drp_rdy(drp_rdy),
        .busy(busy),
        .err(err),
        .timeout(timeout),
        .wb(wb)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [15:0] addr, input logic [15:0] di, input logic we_in);
        drp_en   = 1'b1;
        drp_addr = addr;
        drp_di   = di;
        drp_we   = we_in;
    endtask

    // Transaction-level reference: an access is live from its accepting edge
    // until the first edge where the slave answers or its age reaches TO.
    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_adr = 16'h0000;
            m_dat = 16'h0000;
            m_we  = 1'b0;
            m_do  = 16'h0000;
            m_rdy = 1'b0;
            m_err = 1'b0;
            m_to  = 1'b0;
        end else begin
            m_rdy = 1'b0;
            m_err = 1'b0;
            m_to  = 1'b0;
            if (!m_active) begin
                if (drp_en) begin
                    m_adr = drp_addr;
                    m_dat = drp_di;
                    m_we  = drp_we;
                    m_age = 0;
                    m_active = 1'b1;
                end
            end else begin
                m_age++;
                if (wb.wb_err_i) begin
                    m_do = 16'h0000;
                    m_rdy = 1'b1;
                    m_err = 1'b1;
                    m_active = 1'b0;
                end else if (wb.wb_ack_i) begin
                    if (!m_we) m_do = wb.wb_dat_i;
                    m_rdy = 1'b1;
                    m_active = 1'b0;
                end else if (m_age == TO) begin
                    m_do = 16'h0000;
                    m_rdy = 1'b1;
                    m_err = 1'b1;
                    m_to  = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
    end

    // Every clock, compare all DUT outputs against the model.
    always @(negedge clk) begin
        if (compare_on) begin
            check_output("cyc", wb.wb_cyc_o, m_active);
            check_output("stb", wb.wb_stb_o, m_active);
            check_output("busy", busy, m_active);
            check_output("sel", wb.wb_sel_o, 2'b11);
            check_output("adr", wb.wb_adr_o, m_adr);
            check_output("dat_o", wb.wb_dat_o, m_dat);
            check_output("we", wb.wb_we_o, m_we);
            check_output("rdy", drp_rdy, m_rdy);
            check_output("err", err, m_err);
            check_output("timeout", timeout, m_to);
            check_output("drp_do", drp_do, m_do);
        end
    end

    // Wishbone slave: counts wait states from the first clock of a cycle,
    // then answers; in random mode it also toggles ack/err while idle.
    always @(negedge clk) begin
        if (!wb.wb_cyc_o) begin
            slave_active = 1'b0;
        end else if (!slave_active) begin
            slave_active = 1'b1;
            if (cfg_random) begin
                int r;
                wait_left = $urandom_range(0, 9);
                r = $urandom_range(0, 15);
                kind = (r < 11) ? K_ACK : (r < 13) ? K_ERR : (r < 14) ? K_BOTH : K_NONE;
            end else begin
                wait_left = cfg_wait;
                kind = cfg_kind;
            end
        end
        if (slave_active) begin
            if (wait_left == 0) begin
                wb.wb_ack_i = (kind == K_ACK) || (kind == K_BOTH);
                wb.wb_err_i = (kind == K_ERR) || (kind == K_BOTH);
                wb.wb_dat_i = cfg_random ? 16'($urandom) : cfg_data;
            end else begin
                wb.wb_ack_i = 1'b0;
                wb.wb_err_i = 1'b0;
                wb.wb_dat_i = 16'($urandom);
                wait_left--;
            end
        end else if (cfg_random) begin
            wb.wb_ack_i = ($urandom_range(0, 3) == 0);
            wb.wb_err_i = ($urandom_range(0, 7) == 0);
            wb.wb_dat_i = 16'($urandom);
        end else begin
            wb.wb_ack_i = 1'b0;
            wb.wb_err_i = 1'b0;
            wb.wb_dat_i = 16'($urandom);
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int k;
        rst = 1'b1;
        drp_en = 1'b0;
        drp_we = 1'b0;
        drp_addr = 16'h0000;
        drp_di = 16'h0000;
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        wb.wb_dat_i = 16'h0000;

        repeat (3) @(negedge clk);
        compare_on = 1'b1;
        check_output("rst_cyc", wb.wb_cyc_o, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_do", drp_do, 16'h0000);
        check_output("rst_adr", wb.wb_adr_o, 16'h0000);
        rst = 1'b0;

        // zero-wait read
        cfg_wait = 0; cfg_kind = K_ACK; cfg_data = 16'hBEEF;
        @(negedge clk); apply_stimulus(16'h0012, 16'h0000, 1'b0);
        @(negedge clk); drp_en = 1'b0;
        check_output("rd_adr", wb.wb_adr_o, 16'h0012);
        check_output("rd_we", wb.wb_we_o, 1'b0);
        check_output("rd_cyc", wb.wb_cyc_o, 1'b1);
        @(negedge clk);
        check_output("rd_rdy", drp_rdy, 1'b1);
        check_output("rd_do", drp_do, 16'hBEEF);
        check_output("rd_cyc_low", wb.wb_cyc_o, 1'b0);

        // write with three wait states
        cfg_wait = 3; cfg_data = 16'h0F0F;
        @(negedge clk); apply_stimulus(16'h0034, 16'h5A5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drp_en = 1'b0;
            check_output("wr_dat_o", wb.wb_dat_o, 16'h5A5A);
            check_output("wr_cyc", wb.wb_cyc_o, 1'b1);
            check_output("wr_rdy_early", drp_rdy, 1'b0);
        end
        @(negedge clk);
        check_output("wr_rdy", drp_rdy, 1'b1);
        check_output("wr_do_kept", drp_do, 16'hBEEF);
        @(negedge clk);
        check_output("wr_rdy_once", drp_rdy, 1'b0);

        // bus error on read
        cfg_wait = 1; cfg_kind = K_ERR; cfg_data = 16'h7777;
        @(negedge clk); apply_stimulus(16'h0040, 16'h0000, 1'b0);
        @(negedge clk); drp_en = 1'b0;
        @(negedge clk);
        check_output("be_rdy_early", drp_rdy, 1'b0);
        @(negedge clk);
        check_output("be_rdy", drp_rdy, 1'b1);
        check_output("be_err", err, 1'b1);
        check_output("be_to", timeout, 1'b0);
        check_output("be_do", drp_do, 16'h0000);
        check_output("be_cyc", wb.wb_cyc_o, 1'b0);

        // slave never answers: abort after TO clocks
        cfg_kind = K_NONE;
        @(negedge clk); apply_stimulus(16'h0050, 16'h0000, 1'b0);
        for (int i = 1; i <= TO; i++) begin
            @(negedge clk); drp_en = 1'b0;
            check_output("to_wait_rdy", drp_rdy, 1'b0);
            check_output("to_wait_cyc", wb.wb_cyc_o, 1'b1);
        end
        @(negedge clk);
        check_output("to_rdy", drp_rdy, 1'b1);
        check_output("to_err", err, 1'b1);
        check_output("to_flag", timeout, 1'b1);
        check_output("to_cyc", wb.wb_cyc_o, 1'b0);

        // back-to-back request plus a stray request while busy
        cfg_kind = K_ACK; cfg_wait = 2; cfg_data = 16'h2222;
        @(negedge clk); apply_stimulus(16'h0060, 16'h0000, 1'b0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk); drp_en = 1'b0;
            if (drp_rdy) break;
        end
        check_output("b2b_first_rdy", drp_rdy, 1'b1);
        cfg_wait = 3;
        apply_stimulus(16'h0061, 16'h1111, 1'b1);
        @(negedge clk); drp_en = 1'b0;
        check_output("b2b_cyc", wb.wb_cyc_o, 1'b1);
        check_output("b2b_adr", wb.wb_adr_o, 16'h0061);
        @(negedge clk); apply_stimulus(16'h0099, 16'h0000, 1'b0);
        @(negedge clk); drp_en = 1'b0;
        check_output("stray_adr", wb.wb_adr_o, 16'h0061);
        @(negedge clk);
        check_output("stray_we", wb.wb_we_o, 1'b1);
        @(negedge clk);
        check_output("b2b_rdy", drp_rdy, 1'b1);
        @(negedge clk);
        check_output("stray_no_cycle", wb.wb_cyc_o, 1'b0);

        // reset in the middle of a cycle
        cfg_wait = 5;
        @(negedge clk); apply_stimulus(16'h0070, 16'h0000, 1'b0);
        @(negedge clk); drp_en = 1'b0;
        @(negedge clk);
        check_output("mr_cyc_before", wb.wb_cyc_o, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_output("mr_cyc", wb.wb_cyc_o, 1'b0);
        check_output("mr_stb", wb.wb_stb_o, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output("mr_no_rdy", drp_rdy, 1'b0);
        end
        cfg_wait = 0; cfg_data = 16'h1234;
        @(negedge clk); apply_stimulus(16'h0071, 16'h0000, 1'b0);
        @(negedge clk); drp_en = 1'b0;
        check_output("mr_next_cyc", wb.wb_cyc_o, 1'b1);
        @(negedge clk);
        check_output("mr_next_rdy", drp_rdy, 1'b1);
        check_output("mr_next_do", drp_do, 16'h1234);

        // randomized traffic, including stray requests and rare resets
        cfg_random = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge clk);
            drp_en = 1'b0;
            rst = 1'b0;
            r = $urandom_range(0, 299);
            if (r == 0) begin
                rst = 1'b1;
            end else if (r < 120) begin
                apply_stimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        @(negedge clk);
        drp_en = 1'b0;
        rst = 1'b0;
        cfg_random = 1'b0;
        repeat (20) @(negedge clk);
        check_output("drain_idle", busy, 1'b0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
